// File: rtl/multi_spi_master_if.sv
// Bus bundle for multi_spi_master: transfer request and configuration,
// shared SPI pins, per-channel chip selects/update lines and the receive result.
interface multi_spi_master_if #(
   parameter int MAXWIDTH = 128,
   parameter int NCHAN    = 4,
   parameter int DIVW     = 8
) ();
   localparam int CHW = $clog2(NCHAN);

   logic                iTrig;
   logic [CHW-1:0]      iChan;
   logic [7:0]          iDataWidth;
   logic [DIVW-1:0]     iDiv;
   logic                iCpol;
   logic                iCpha;
   logic                iAutoUpdate;
   logic                iUpdate;
   logic [MAXWIDTH-1:0] iData;
   logic                iMiso;
   logic                oSclk;
   logic                oMosi;
   logic [NCHAN-1:0]    oCsN;
   logic [NCHAN-1:0]    oUpdate;
   logic [MAXWIDTH-1:0] oRxData;
   logic                oRxValid;
   logic                oReady;

   modport master (
      input  iTrig, iChan, iDataWidth, iDiv, iCpol, iCpha, iAutoUpdate, iUpdate, iData, iMiso,
      output oSclk, oMosi, oCsN, oUpdate, oRxData, oRxValid, oReady
   );

   modport slave (
      output iTrig, iChan, iDataWidth, iDiv, iCpol, iCpha, iAutoUpdate, iUpdate, iData, iMiso,
      input  oSclk, oMosi, oCsN, oUpdate, oRxData, oRxValid, oReady
   );
endinterface

// File: rtl/multi_spi_master.sv
// Multi-channel SPI master: runtime SCLK divider, per-transfer CPOL/CPHA, MISO capture
// and per-channel IO-update pulse (auto, optionally delayed, or manual pass-through).
module multi_spi_master #(
   parameter int MAXWIDTH    = 128,
   parameter int NCHAN       = 4,
   parameter int DIVW        = 8,
   parameter int UPDATEDELAY = 0
) (
   input logic                 iClk,
   input logic                 iRstN,
   multi_spi_master_if.master  bus
);
   localparam int CHW = $clog2(NCHAN);
   localparam int EW  = $clog2(2 * MAXWIDTH + 1);

   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, WAIT} stateT;

   stateT               stateReg, stateNext;
   logic [DIVW-1:0]     cntReg, cntNext, divReg, divNext;
   logic                cpolReg, cpolNext, cphaReg, cphaNext, autoReg, autoNext;
   logic [CHW-1:0]      chanReg, chanNext;
   logic [EW-1:0]       edgeTotalReg, edgeTotalNext, edgeCntReg, edgeCntNext;
   logic [MAXWIDTH-1:0] txReg, txNext, rxReg, rxNext, rxDataReg, rxDataNext;
   logic                sclkReg, sclkNext, mosiReg, mosiNext;
   logic                rxValidReg, rxValidNext, pulseReg, pulseNext;
   logic [NCHAN-1:0]    csNReg, csNNext;
   logic [3:0]          waitReg, waitNext;

   logic                tick, accept, leading, lastEdge, doSample, doDrive;
   logic                readyInt, manualUpd;
   logic [EW-1:0]       edgeInc, edgeTotalIn;

   assign tick     = (cntReg == '0);
   assign accept   = bus.iTrig && (bus.iDataWidth != 8'd0) && (int'(bus.iChan) < NCHAN);
   assign edgeInc  = edgeCntReg + EW'(1);
   // SCLK edges are numbered from 1: odd (edge counter even before the toggle) is leading.
   assign leading  = ~edgeCntReg[0];
   assign lastEdge = (edgeInc == edgeTotalReg);
   assign doSample = leading ^ cphaReg;
   assign doDrive  = cphaReg ? leading : (~leading & ~lastEdge);
   assign edgeTotalIn = (int'(bus.iDataWidth) > MAXWIDTH) ? EW'(2 * MAXWIDTH)
                                                          : EW'(2 * int'(bus.iDataWidth));

   always_comb begin
      stateNext     = stateReg;
      cntNext       = cntReg;
      divNext       = divReg;
      cpolNext      = cpolReg;
      cphaNext      = cphaReg;
      autoNext      = autoReg;
      chanNext      = chanReg;
      edgeTotalNext = edgeTotalReg;
      edgeCntNext   = edgeCntReg;
      txNext        = txReg;
      rxNext        = rxReg;
      rxDataNext    = rxDataReg;
      sclkNext      = sclkReg;
      mosiNext      = mosiReg;
      csNNext       = csNReg;
      waitNext      = waitReg;
      rxValidNext   = 1'b0;
      pulseNext     = 1'b0;

      if (stateReg == LEAD || stateReg == SHIFT || stateReg == TRAIL)
         cntNext = tick ? divReg : cntReg - DIVW'(1);

      case (stateReg)
         IDLE: begin
            if (accept) begin
               stateNext     = LEAD;
               cntNext       = bus.iDiv;
               divNext       = bus.iDiv;
               cpolNext      = bus.iCpol;
               cphaNext      = bus.iCpha;
               autoNext      = bus.iAutoUpdate;
               chanNext      = bus.iChan;
               edgeTotalNext = edgeTotalIn;
               edgeCntNext   = '0;
               // CPHA=0 presents the MSB before the first edge; CPHA=1 drives it on the leading edge.
               txNext        = bus.iCpha ? bus.iData : (bus.iData << 1);
               mosiNext      = bus.iCpha ? 1'b0 : bus.iData[MAXWIDTH-1];
               rxNext        = '0;
               sclkNext      = bus.iCpol;
               csNNext       = ~(NCHAN'(1) << bus.iChan);
            end
         end
         LEAD: begin
            if (tick)
               stateNext = SHIFT;
         end
         SHIFT: begin
            if (tick) begin
               sclkNext    = ~sclkReg;
               edgeCntNext = edgeInc;
               if (doSample)
                  rxNext = {rxReg[MAXWIDTH-2:0], bus.iMiso};
               if (doDrive) begin
                  mosiNext = txReg[MAXWIDTH-1];
                  txNext   = txReg << 1;
               end
               if (lastEdge)
                  stateNext = TRAIL;
            end
         end
         TRAIL: begin
            if (tick) begin
               csNNext     = '1;
               mosiNext    = 1'b0;
               rxValidNext = 1'b1;
               rxDataNext  = rxReg;
               if (UPDATEDELAY == 0) begin
                  stateNext = IDLE;
                  pulseNext = autoReg;
               end else begin
                  stateNext = WAIT;
                  waitNext  = 4'(UPDATEDELAY - 1);
               end
            end
         end
         WAIT: begin
            if (waitReg == '0) begin
               stateNext = IDLE;
               pulseNext = autoReg;
            end else begin
               waitNext = waitReg - 4'd1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         stateReg     <= IDLE;
         cntReg       <= '0;
         divReg       <= '0;
         cpolReg      <= 1'b0;
         cphaReg      <= 1'b0;
         autoReg      <= 1'b1;
         chanReg      <= '0;
         edgeTotalReg <= '0;
         edgeCntReg   <= '0;
         txReg        <= '0;
         rxReg        <= '0;
         rxDataReg    <= '0;
         sclkReg      <= 1'b0;
         mosiReg      <= 1'b0;
         csNReg       <= '1;
         waitReg      <= '0;
         rxValidReg   <= 1'b0;
         pulseReg     <= 1'b0;
      end else begin
         stateReg     <= stateNext;
         cntReg       <= cntNext;
         divReg       <= divNext;
         cpolReg      <= cpolNext;
         cphaReg      <= cphaNext;
         autoReg      <= autoNext;
         chanReg      <= chanNext;
         edgeTotalReg <= edgeTotalNext;
         edgeCntReg   <= edgeCntNext;
         txReg        <= txNext;
         rxReg        <= rxNext;
         rxDataReg    <= rxDataNext;
         sclkReg      <= sclkNext;
         mosiReg      <= mosiNext;
         csNReg       <= csNNext;
         waitReg      <= waitNext;
         rxValidReg   <= rxValidNext;
         pulseReg     <= pulseNext;
      end
   end

   assign readyInt  = (stateReg == IDLE);
   // Manual update is a live pass-through gated by idle; it is forced low while reset is held.
   assign manualUpd = ~bus.iAutoUpdate & bus.iUpdate & readyInt & iRstN;

   assign bus.oSclk    = sclkReg;
   assign bus.oMosi    = mosiReg;
   assign bus.oCsN     = csNReg;
   assign bus.oRxData  = rxDataReg;
   assign bus.oRxValid = rxValidReg;
   assign bus.oReady   = readyInt;

   generate
      for (genvar gi = 0; gi < NCHAN; gi++) begin : gUpdate
         assign bus.oUpdate[gi] = (chanReg == CHW'(gi)) && (pulseReg || manualUpd);
      end
   endgenerate
endmodule

// File: tb/tb_multi_spi_master.sv
// Directed bench for multi_spi_master: vector table of single transfers plus
// hand-written sequences for update timing, busy triggers, back-to-back and reset.
module tb_multi_spi_master;
   logic clk;
   logic rstN;
   logic loop0, miso0Const;
   int   total = 0;
   int   bad   = 0;
   logic [1:0] lastChan;

   multi_spi_master_if #(.MAXWIDTH(128), .NCHAN(4), .DIVW(8)) bus0 ();
   multi_spi_master_if #(.MAXWIDTH(128), .NCHAN(4), .DIVW(8)) bus4 ();

   multi_spi_master #(.MAXWIDTH(128), .NCHAN(4), .DIVW(8), .UPDATEDELAY(0)) dut0 (
      .iClk(clk), .iRstN(rstN), .bus(bus0)
   );
   multi_spi_master #(.MAXWIDTH(128), .NCHAN(4), .DIVW(8), .UPDATEDELAY(4)) dut4 (
      .iClk(clk), .iRstN(rstN), .bus(bus4)
   );

   assign bus0.iMiso = loop0 ? bus0.oMosi : miso0Const;
   assign bus4.iMiso = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]   chan;
      logic [7:0]   width;
      logic [7:0]   div;
      logic         cpol;
      logic         cpha;
      logic         loop;
      logic         misoConst;
      logic [127:0] data;
      int           expCsLow;
      int           expRises;
      int           expPeriod;
      logic [127:0] expMosi;
      logic [127:0] expRx;
   } vecT;

   vecT vecs[7];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic runXfer(input int idx);
      vecT          v;
      int           csLow, rises, r1, r2, cyc;
      logic         prev, lead, seen;
      logic [127:0] mosiBits;
      logic [3:0]   expCs, expUpd;
      v      = vecs[idx];
      expCs  = ~(4'b0001 << v.chan);
      expUpd = 4'b0001 << v.chan;
      @(negedge clk);
      bus0.iChan       = v.chan;
      bus0.iDataWidth  = v.width;
      bus0.iDiv        = v.div;
      bus0.iCpol       = v.cpol;
      bus0.iCpha       = v.cpha;
      bus0.iData       = v.data;
      bus0.iAutoUpdate = 1'b1;
      bus0.iUpdate     = 1'b0;
      loop0            = v.loop;
      miso0Const       = v.misoConst;
      bus0.iTrig       = 1'b1;
      @(negedge clk);
      bus0.iTrig = 1'b0;
      check($sformatf("v%0d cs_first", idx), 128'(bus0.oCsN), 128'(expCs));
      check($sformatf("v%0d ready_busy", idx), 128'(bus0.oReady), 128'(1'b0));
      check($sformatf("v%0d sclk_idle", idx), 128'(bus0.oSclk), 128'(v.cpol));
      check($sformatf("v%0d mosi_first", idx), 128'(bus0.oMosi), 128'(v.cpha ? 1'b0 : v.data[127]));
      csLow = 1; rises = 0; r1 = -1; r2 = -1; cyc = 0;
      prev = bus0.oSclk; mosiBits = '0; seen = 1'b0;
      for (int n = 0; n < 2000 && !seen; n++) begin
         @(negedge clk);
         cyc++;
         if (bus0.oRxValid) begin
            seen = 1'b1;
         end else begin
            if (bus0.oCsN != 4'hF) csLow++;
            if (bus0.oSclk != prev) begin
               lead = (bus0.oSclk != v.cpol);
               if (lead != v.cpha) mosiBits = {mosiBits[126:0], bus0.oMosi};
               if (bus0.oSclk) begin
                  rises++;
                  if (r1 < 0) r1 = cyc;
                  else if (r2 < 0) r2 = cyc;
               end
               prev = bus0.oSclk;
            end
         end
      end
      check($sformatf("v%0d rxvalid_seen", idx), 128'(seen), 128'(1'b1));
      check($sformatf("v%0d cs_low_cycles", idx), 128'(csLow), 128'(v.expCsLow));
      check($sformatf("v%0d sclk_rises", idx), 128'(rises), 128'(v.expRises));
      if (v.expPeriod != 0)
         check($sformatf("v%0d sclk_period", idx), 128'(r2 - r1), 128'(v.expPeriod));
      check($sformatf("v%0d mosi_bits", idx), mosiBits, v.expMosi);
      check($sformatf("v%0d rxdata", idx), bus0.oRxData, v.expRx);
      check($sformatf("v%0d cs_release", idx), 128'(bus0.oCsN), 128'(4'hF));
      check($sformatf("v%0d update_pulse", idx), 128'(bus0.oUpdate), 128'(expUpd));
      check($sformatf("v%0d ready_end", idx), 128'(bus0.oReady), 128'(1'b1));
      check($sformatf("v%0d sclk_end", idx), 128'(bus0.oSclk), 128'(v.cpol));
      check($sformatf("v%0d mosi_idle", idx), 128'(bus0.oMosi), 128'(1'b0));
      @(negedge clk);
      check($sformatf("v%0d rxvalid_1cyc", idx), 128'(bus0.oRxValid), 128'(1'b0));
      check($sformatf("v%0d update_1cyc", idx), 128'(bus0.oUpdate), 128'(4'h0));
      $display("xfer v%0d chan=%0d width=%0d div=%0d mode=%0d csLow=%0d rises=%0d rx=%0h",
               idx, v.chan, v.width, v.div, {v.cpol, v.cpha}, csLow, rises, bus0.oRxData);
      lastChan = v.chan;
   endtask

   initial begin
      int   viol, badCs, segs, gap, k, early;
      logic seen, found, prevLow, inLow;

      rstN = 1'b0;
      loop0 = 1'b0; miso0Const = 1'b0;
      bus0.iTrig = 0; bus0.iChan = 0; bus0.iDataWidth = 0; bus0.iDiv = 0; bus0.iCpol = 0;
      bus0.iCpha = 0; bus0.iAutoUpdate = 1; bus0.iUpdate = 0; bus0.iData = '0;
      bus4.iTrig = 0; bus4.iChan = 0; bus4.iDataWidth = 0; bus4.iDiv = 0; bus4.iCpol = 0;
      bus4.iCpha = 0; bus4.iAutoUpdate = 1; bus4.iUpdate = 0; bus4.iData = '0;
      lastChan = 2'd0;

      //          chan   width   div   cpol cpha loop miso data                        cs   rise per  mosi            rx
      vecs[0] = '{2'd2, 8'd8,   8'd0, 1'b0, 1'b0, 1'b1, 1'b0, {8'hA5, 120'd0},          18,  8,   2, 128'hA5,        128'hA5};
      vecs[1] = '{2'd0, 8'd16,  8'd3, 1'b1, 1'b1, 1'b0, 1'b1, {16'h1234, 112'd0},       136, 16,  8, 128'h1234,      128'hFFFF};
      vecs[2] = '{2'd1, 8'd12,  8'd1, 1'b0, 1'b1, 1'b1, 1'b0, {12'hABC, 116'd0},        52,  12,  4, 128'hABC,       128'hABC};
      vecs[3] = '{2'd3, 8'd5,   8'd2, 1'b1, 1'b0, 1'b0, 1'b0, {5'b10110, 123'd0},       36,  5,   6, 128'h16,        128'h0};
      vecs[4] = '{2'd0, 8'd1,   8'd0, 1'b0, 1'b0, 1'b1, 1'b0, {1'b1, 127'd0},           4,   1,   0, 128'h1,         128'h1};
      vecs[5] = '{2'd3, 8'd200, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                  128'hF0E1D2C3B4A5968778695A4B3C2D1E0F,                                258, 128, 2,
                  128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F};
      vecs[6] = '{2'd2, 8'd8,   8'd0, 1'b0, 1'b0, 1'b1, 1'b0, {8'h3C, {120{1'b1}}},     18,  8,   2, 128'h3C,        128'h3C};

      @(negedge clk);
      check("rst csn", 128'(bus0.oCsN), 128'(4'hF));
      check("rst sclk", 128'(bus0.oSclk), 128'(1'b0));
      check("rst mosi", 128'(bus0.oMosi), 128'(1'b0));
      check("rst update", 128'(bus0.oUpdate), 128'(4'h0));
      check("rst rxvalid", 128'(bus0.oRxValid), 128'(1'b0));
      check("rst rxdata", bus0.oRxData, 128'h0);
      check("rst ready", 128'(bus0.oReady), 128'(1'b1));
      check("rst ready dly", 128'(bus4.oReady), 128'(1'b1));
      repeat (2) @(negedge clk);
      rstN = 1'b1;

      for (int i = 0; i < 7; i++) runXfer(i);

      // Manual update: follows iUpdate while idle on the last latched channel, low while busy.
      @(negedge clk);
      bus0.iAutoUpdate = 1'b0; bus0.iUpdate = 1'b1;
      #1;
      check("man idle_pre", 128'(bus0.oUpdate), 128'(4'b0001 << lastChan));
      bus0.iChan = 2'd1; bus0.iDataWidth = 8'd4; bus0.iDiv = 8'd0; bus0.iCpol = 0; bus0.iCpha = 0;
      bus0.iTrig = 1'b1;
      @(negedge clk);
      bus0.iTrig = 1'b0;
      viol = 0; seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
         if (bus0.oRxValid) seen = 1'b1;
         else begin
            if (bus0.oUpdate != 4'h0) viol++;
            @(negedge clk);
         end
      end
      check("man seen", 128'(seen), 128'(1'b1));
      check("man busy_low", 128'(viol), 128'(0));
      check("man done_upd", 128'(bus0.oUpdate), 128'(4'b0010));
      bus0.iUpdate = 1'b0;
      #1;
      check("man no_internal", 128'(bus0.oUpdate), 128'(4'h0));
      bus0.iUpdate = 1'b1;
      #1;
      check("man follow", 128'(bus0.oUpdate), 128'(4'b0010));
      bus0.iUpdate = 1'b0; bus0.iAutoUpdate = 1'b1;
      $display("xfer manual-update chan=1 busyViolations=%0d", viol);

      // Triggers while busy are ignored and not queued; width 0 is rejected.
      @(negedge clk);
      bus0.iChan = 2'd0; bus0.iDataWidth = 8'd4; bus0.iDiv = 8'd1; bus0.iTrig = 1'b1;
      @(negedge clk);
      bus0.iTrig = 1'b0;
      badCs = 0; seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clk);
         if (n == 4) begin
            bus0.iTrig = 1'b1; bus0.iChan = 2'd3; bus0.iDataWidth = 8'd8;
         end else begin
            bus0.iTrig = 1'b0;
         end
         if (bus0.oCsN != 4'b1110 && bus0.oCsN != 4'hF) badCs++;
         if (bus0.oRxValid) seen = 1'b1;
      end
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (bus0.oCsN != 4'hF || !bus0.oReady) badCs++;
      end
      check("busy seen", 128'(seen), 128'(1'b1));
      check("busy ignored", 128'(badCs), 128'(0));
      @(negedge clk);
      bus0.iDataWidth = 8'd0; bus0.iChan = 2'd1; bus0.iTrig = 1'b1;
      @(negedge clk);
      bus0.iTrig = 1'b0;
      viol = 0;
      for (int n = 0; n < 5; n++) begin
         if (bus0.oCsN != 4'hF || !bus0.oReady) viol++;
         @(negedge clk);
      end
      check("zero width ignored", 128'(viol), 128'(0));
      $display("xfer busy-trigger badCs=%0d zeroWidthViolations=%0d", badCs, viol);

      // Back-to-back: iTrig held high is accepted in the cycle oReady returns.
      @(negedge clk);
      bus0.iChan = 2'd1; bus0.iDataWidth = 8'd2; bus0.iDiv = 8'd0; bus0.iData = {2'b10, 126'd0};
      loop0 = 1'b0; miso0Const = 1'b0; bus0.iTrig = 1'b1;
      segs = 0; gap = 0; prevLow = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         inLow = (bus0.oCsN != 4'hF);
         if (inLow && !prevLow) begin
            segs++;
            if (segs == 2) bus0.iTrig = 1'b0;
         end
         if (!inLow && segs == 1) gap++;
         prevLow = inLow;
      end
      bus0.iTrig = 1'b0;
      check("b2b segments", 128'(segs), 128'(2));
      check("b2b cs_gap", 128'(gap), 128'(1));
      $display("xfer back-to-back segments=%0d gap=%0d", segs, gap);

      // Delayed auto update on the UPDATEDELAY=4 instance.
      @(negedge clk);
      bus4.iChan = 2'd1; bus4.iDataWidth = 8'd8; bus4.iDiv = 8'd0; bus4.iData = {8'hA5, 120'd0};
      bus4.iTrig = 1'b1;
      @(negedge clk);
      bus4.iTrig = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         if (bus4.oRxValid) seen = 1'b1;
      end
      check("dly seen", 128'(seen), 128'(1'b1));
      check("dly ready_at_cs", 128'(bus4.oReady), 128'(1'b0));
      check("dly upd_at_cs", 128'(bus4.oUpdate), 128'(4'h0));
      check("dly cs_release", 128'(bus4.oCsN), 128'(4'hF));
      found = 1'b0; early = 0; k = 0;
      for (int n = 1; n <= 20 && !found; n++) begin
         @(negedge clk);
         k = n;
         if (n == 1) check("dly rxvalid_1cyc", 128'(bus4.oRxValid), 128'(1'b0));
         if (bus4.oUpdate != 4'h0) found = 1'b1;
         else if (bus4.oReady) early++;
      end
      check("dly update_delay", 128'(k), 128'(4));
      check("dly update_chan", 128'(bus4.oUpdate), 128'(4'b0010));
      check("dly ready_with_upd", 128'(bus4.oReady), 128'(1'b1));
      check("dly ready_early", 128'(early), 128'(0));
      @(negedge clk);
      check("dly update_1cyc", 128'(bus4.oUpdate), 128'(4'h0));
      $display("xfer delayed-update chan=1 delay=%0d", k);

      // Asynchronous reset in the middle of SHIFT.
      @(negedge clk);
      bus0.iChan = 2'd2; bus0.iDataWidth = 8'd16; bus0.iDiv = 8'd2; bus0.iCpol = 1'b1;
      bus0.iCpha = 1'b0; bus0.iData = {16'hC3C3, 112'd0}; bus0.iTrig = 1'b1;
      @(negedge clk);
      bus0.iTrig = 1'b0;
      repeat (12) @(negedge clk);
      check("arst pre_cs", 128'(bus0.oCsN), 128'(4'b1011));
      rstN = 1'b0;
      #1;
      check("arst csn", 128'(bus0.oCsN), 128'(4'hF));
      check("arst sclk", 128'(bus0.oSclk), 128'(1'b0));
      check("arst ready", 128'(bus0.oReady), 128'(1'b1));
      check("arst mosi", 128'(bus0.oMosi), 128'(1'b0));
      check("arst rxvalid", 128'(bus0.oRxValid), 128'(1'b0));
      check("arst update", 128'(bus0.oUpdate), 128'(4'h0));
      @(negedge clk);
      rstN = 1'b1;
      viol = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus0.oRxValid || bus0.oUpdate != 4'h0 || bus0.oCsN != 4'hF) viol++;
      end
      check("arst no_completion", 128'(viol), 128'(0));
      $display("xfer async-reset postViolations=%0d", viol);
      bus0.iCpol = 1'b0;
      runXfer(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
